pipe_stage_buf: RTL and testbench

- Generic, parametrised pipeline stage buffer placed between any two CPU stages (fetch→decode, decode→execute, execute→mem).
- Generalises the single-register stage hand-off: a DEPTH-entry in-order queue carrying a WIDTH-bit payload.
- Speaks the existing valid/stall/flush protocol, with flush propagated upstream.
- Adds occupancy reporting plus saturating stall/flush event counters for the debug ports.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_buf_mem.sv | 25 ++
 rtl/pipe_stage_buf.sv | 107 ++++++++++
 tb/tb_pipe_stage_buf.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage buffers: occupancy sizing, saturating counter step,
// and the bubble instruction substituted for an invalid head.
package pipe_pkg;

    localparam logic [31:0] PIPE_NOP_INST = 32'hE1A00000;

    // Occupancy must represent 0..DEPTH inclusive, hence one bit more than the pointers.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        if (width >= 32) begin
            max_val = '1;
        end else begin
            max_val = (32'd1 << width) - 32'd1;
        end
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// The array is deliberately unreset; validity is tracked by the owning buffer.
module pipe_buf_mem #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_stage_buf.sv
// In-order DEPTH-entry hand-off buffer between two pipeline stages using the valid/stall/flush
// protocol, with occupancy reporting and saturating stall/flush event counters.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         valid_i,
    output logic                         stall_o,
    input  logic                         flush_i,
    output logic                         flush_o,
    output logic [WIDTH-1:0]             data_o,
    output logic                         valid_o,
    input  logic                         stall_i,
    output logic [occ_width(DEPTH)-1:0]  occupancy_o,
    output logic [CNT_W-1:0]             stall_cnt_o,
    output logic [CNT_W-1:0]             flush_cnt_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = occ_width(DEPTH);

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]  count_q, count_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             push, pop;

    // Handshake outputs decode registered count only, so stall_o has no path from inputs.
    always_comb begin
        valid_o     = (count_q != '0);
        stall_o     = (count_q == OccW'(DEPTH));
        occupancy_o = count_q;
        flush_o     = flush_i;
        stall_cnt_o = stall_cnt_q;
        flush_cnt_o = flush_cnt_q;
    end

    assign push = valid_i & ~stall_o & ~flush_i;
    assign pop  = valid_o & ~stall_i & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + OccW'(push) - OccW'(pop);
        end
    end

    // Counters survive flush; only reset clears them.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_o) begin
            stall_cnt_d = CNT_W'(sat_inc(32'(stall_cnt_q), CNT_W));
        end
        if (flush_i) begin
            flush_cnt_d = CNT_W'(sat_inc(32'(flush_cnt_q), CNT_W));
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    pipe_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (data_o)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: queue-based reference model plus directed scenarios.
module tb_pipe_stage_buf;

    localparam int unsigned D    = 4;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] data_i;
    logic        valid_i, stall_i, flush_i;
    logic        stall_o, flush_o, valid_o;
    logic [31:0] data_o;
    logic [2:0]  occ_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    logic [31:0] d2_data_i;
    logic        d2_valid_i, d2_stall_i, d2_flush_i;
    logic        d2_stall_o, d2_flush_o, d2_valid_o;
    logic [31:0] d2_data_o;
    logic [1:0]  d2_occ_o;
    logic [7:0]  d2_stall_cnt_o, d2_flush_cnt_o;

    pipe_stage_buf #(.WIDTH(32), .DEPTH(D), .CNT_W(CW)) dut (
        .clk_i       (clk),
        .reset_i     (rst_n),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .stall_o     (stall_o),
        .flush_i     (flush_i),
        .flush_o     (flush_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .stall_i     (stall_i),
        .occupancy_o (occ_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .CNT_W(8)) dut2 (
        .clk_i       (clk),
        .reset_i     (rst_n),
        .data_i      (d2_data_i),
        .valid_i     (d2_valid_i),
        .stall_o     (d2_stall_o),
        .flush_i     (d2_flush_i),
        .flush_o     (d2_flush_o),
        .data_o      (d2_data_o),
        .valid_o     (d2_valid_o),
        .stall_i     (d2_stall_i),
        .occupancy_o (d2_occ_o),
        .stall_cnt_o (d2_stall_cnt_o),
        .flush_cnt_o (d2_flush_cnt_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of payloads plus two saturating event counts.
    logic [31:0] mq[$];
    int          m_stall = 0;
    int          m_flush = 0;
    bit          m_full;

    always @(posedge clk) begin
        if (rst_n) begin
            m_full = (mq.size() == D);
            if (m_full && m_stall < CMAX) m_stall++;
            if (flush_i) begin
                if (m_flush < CMAX) m_flush++;
                mq.delete();
            end else begin
                if (mq.size() != 0 && !stall_i) void'(mq.pop_front());
                if (valid_i && !m_full) mq.push_back(data_i);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_valid", 64'(valid_o), 64'(mq.size() != 0));
            chk("m_occ", 64'(occ_o), 64'(mq.size()));
            chk("m_stall_o", 64'(stall_o), 64'(mq.size() == D));
            chk("m_flush_o", 64'(flush_o), 64'(flush_i));
            chk("m_stall_cnt", 64'(stall_cnt_o), 64'(m_stall));
            chk("m_flush_cnt", 64'(flush_cnt_o), 64'(m_flush));
            if (mq.size() != 0) chk("m_data", 64'(data_o), 64'(mq[0]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_i = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        data_i  = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        clear_inputs();
        rst_n = 1'b0;
        mq.delete();
        m_stall = 0;
        m_flush = 0;
        #4;
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        d2_data_i  = '0;
        d2_valid_i = 1'b0;
        d2_stall_i = 1'b0;
        d2_flush_i = 1'b0;
        #12;
        rst_n = 1'b1;

        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_occ", 64'(occ_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_flush_o", 64'(flush_o), 64'd0);
        chk("rst_cnts", {32'(stall_cnt_o), 32'(flush_cnt_o)}, 64'd0);

        // DEPTH=2 instance: single beat latency and drain
        cyc();
        d2_valid_i = 1'b1;
        d2_data_i  = 32'hAAAA0001;
        #1 chk("d2_no_bypass", 64'(d2_valid_o), 64'd0);
        cyc();
        d2_valid_i = 1'b0;
        chk("d2_valid_c1", 64'(d2_valid_o), 64'd1);
        chk("d2_data_c1", 64'(d2_data_o), 64'hAAAA0001);
        chk("d2_occ_c1", 64'(d2_occ_o), 64'd1);
        chk("d2_stall_o", 64'(d2_stall_o), 64'd0);
        cyc();
        chk("d2_valid_c2", 64'(d2_valid_o), 64'd0);
        chk("d2_occ_c2", 64'(d2_occ_o), 64'd0);
        chk("d2_misc", {30'd0, d2_flush_o, 1'b0, 16'd0, d2_stall_cnt_o, d2_flush_cnt_o}, 64'd0);

        // Fill under downstream stall; fifth beat must be refused
        stall_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            valid_i = 1'b1;
            data_i  = 32'(i);
            cyc();
            if (i == 4) chk("full_stall_o", 64'(stall_o), 64'd1);
        end
        valid_i = 1'b0;
        chk("full_occ", 64'(occ_o), 64'd4);
        chk("full_head", 64'(data_o), 64'd1);
        stall_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1 chk("drain_data", 64'(data_o), 64'(i));
            cyc();
        end
        chk("drain_empty", 64'(valid_o), 64'd0);

        // Steady push/pop across several pointer wraps
        do_reset();
        stall_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 32'd100;
        cyc();
        data_i  = 32'd101;
        cyc();
        stall_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            data_i = 32'(102 + k);
            #1;
            chk("steady_occ", 64'(occ_o), 64'd2);
            chk("steady_data", 64'(data_o), 64'(100 + k));
            cyc();
        end
        valid_i = 1'b0;
        chk("steady_tail", 64'(data_o), 64'd120);
        cyc();
        cyc();
        chk("steady_drained", 64'(valid_o), 64'd0);

        // Flush with a same-cycle push
        do_reset();
        stall_i = 1'b1;
        valid_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            data_i = 32'(i);
            cyc();
        end
        flush_i = 1'b1;
        stall_i = 1'b0;
        data_i  = 32'h0000DEAD;
        #1 chk("flush_o_same", 64'(flush_o), 64'd1);
        cyc();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("flush_valid", 64'(valid_o), 64'd0);
        chk("flush_occ", 64'(occ_o), 64'd0);
        chk("flush_cnt", 64'(flush_cnt_o), 64'd1);
        cyc();
        chk("flush_no_dead", 64'(valid_o), 64'd0);

        // Stall counter saturation
        do_reset();
        stall_i = 1'b1;
        valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_i = 32'(i + 50);
            cyc();
        end
        valid_i = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (i == 10) chk("stall_cnt_10", 64'(stall_cnt_o), 64'd10);
        end
        chk("stall_cnt_sat", 64'(stall_cnt_o), 64'd15);
        cyc();
        chk("stall_cnt_hold", 64'(stall_cnt_o), 64'd15);

        // Asynchronous reset mid-stream
        do_reset();
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        stall_i = 1'b1;
        valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_i = 32'(i + 11);
            cyc();
        end
        valid_i = 1'b0;
        cyc();
        stall_i = 1'b0;
        cyc();
        cyc();
        stall_i = 1'b1;
        chk("pre_rst_occ", 64'(occ_o), 64'd2);
        chk("pre_rst_head", 64'(data_o), 64'd13);
        chk("pre_rst_cnts", {32'(stall_cnt_o), 32'(flush_cnt_o)}, {32'd2, 32'd1});
        #2;
        clear_inputs();
        rst_n = 1'b0;
        mq.delete();
        m_stall = 0;
        m_flush = 0;
        #1;
        chk("async_valid", 64'(valid_o), 64'd0);
        chk("async_occ", 64'(occ_o), 64'd0);
        chk("async_cnts", {32'(stall_cnt_o), 32'(flush_cnt_o)}, 64'd0);
        #3;
        rst_n = 1'b1;
        cyc();
        chk("post_rst_valid", 64'(valid_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
